multicycle_ctrl: RTL and testbench

Multicycle sequencer for the single-issue RV32I core. It drives the shared datapath (PC, IR, ALU, register file, memory ports) through fetch, decode, execute, memory and writeback, one instruction at a time. It consumes the instruction decoder's control outputs and the ALU result flag. It owns the instruction and data memory request/acknowledge handshakes and traps on illegal instructions or memory timeouts.

---
 rtl/multicycle_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32I core: steps fetch/decode/execute/memory/writeback,
// owns the imem/dmem handshakes and traps on illegal opcodes or ack timeouts.
module multicycle_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        illegal_instr,
   input  logic        mem_to_reg,
   input  logic        mem_write,
   input  logic        reg_write,
   input  logic        branch,
   input  logic        invert_branch,
   input  logic        jump,
   input  logic [1:0]  next_pc,
   input  logic        alu_nz,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        ir_we,
   output logic        pc_we,
   output logic        rf_we,
   output logic        wb_sel,
   output logic [1:0]  pc_sel,
   output logic        halted,
   output logic [1:0]  err,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_e;

   localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_to_reg_q, mem_to_reg_d;
   logic              mem_write_q, mem_write_d;
   logic              reg_write_q, reg_write_d;
   logic [1:0]        next_pc_q, next_pc_d;
   logic              taken_q, taken_d;
   logic [31:0]       instret_q, instret_d;
   logic [1:0]        err_q, err_d;
   logic              imem_req_q, imem_req_d;
   logic              dmem_req_q, dmem_req_d;
   logic              dmem_we_q, dmem_we_d;
   logic              pc_we_q, pc_we_d;
   logic              rf_we_q, rf_we_d;
   logic              wb_sel_q, wb_sel_d;
   logic [1:0]        pc_sel_q, pc_sel_d;
   logic              halted_q, halted_d;
   logic              imem_fire, dmem_fire, timeout_hit;

   // Outputs are registered from the next state so they stay low during reset
   // while still reflecting the state they belong to.
   assign imem_fire   = imem_req_q & imem_ack;
   assign dmem_fire   = dmem_req_q & dmem_ack;
   assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      mem_to_reg_d = mem_to_reg_q;
      mem_write_d  = mem_write_q;
      reg_write_d  = reg_write_q;
      next_pc_d    = next_pc_q;
      taken_d      = taken_q;
      instret_d    = instret_q;
      err_d        = err_q;

      case (state_q)
         S_FETCH: begin
            if (imem_fire) begin
               state_d = S_DECODE;
            end else if (imem_req_q) begin
               if (timeout_hit) begin
                  state_d = S_TRAP;
                  err_d   = 2'b10;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_DECODE: begin
            mem_to_reg_d = mem_to_reg;
            mem_write_d  = mem_write;
            reg_write_d  = reg_write;
            next_pc_d    = next_pc;
            if (illegal_instr) begin
               state_d = S_TRAP;
               err_d   = 2'b01;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            taken_d = jump | (branch & (alu_nz ^ invert_branch));
            state_d = (mem_to_reg_q | mem_write_q) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (dmem_fire) begin
               state_d = S_WB;
            end else if (timeout_hit) begin
               state_d = S_TRAP;
               err_d   = 2'b11;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
         end
         S_TRAP: state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase

      if (state_d != state_q) begin
         cnt_d = '0;
      end

      imem_req_d = (state_d == S_FETCH);
      dmem_req_d = (state_d == S_MEM);
      dmem_we_d  = (state_d == S_MEM) & mem_write_d;
      pc_we_d    = (state_d == S_WB);
      rf_we_d    = (state_d == S_WB) & reg_write_d;
      wb_sel_d   = (state_d == S_WB) & mem_to_reg_d;
      pc_sel_d   = ((state_d == S_WB) && taken_d) ? next_pc_d : 2'b00;
      halted_d   = (state_d == S_TRAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_FETCH;
         cnt_q        <= '0;
         mem_to_reg_q <= 1'b0;
         mem_write_q  <= 1'b0;
         reg_write_q  <= 1'b0;
         next_pc_q    <= 2'b00;
         taken_q      <= 1'b0;
         instret_q    <= '0;
         err_q        <= 2'b00;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         pc_we_q      <= 1'b0;
         rf_we_q      <= 1'b0;
         wb_sel_q     <= 1'b0;
         pc_sel_q     <= 2'b00;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_to_reg_q <= mem_to_reg_d;
         mem_write_q  <= mem_write_d;
         reg_write_q  <= reg_write_d;
         next_pc_q    <= next_pc_d;
         taken_q      <= taken_d;
         instret_q    <= instret_d;
         err_q        <= err_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         pc_we_q      <= pc_we_d;
         rf_we_q      <= rf_we_d;
         wb_sel_q     <= wb_sel_d;
         pc_sel_q     <= pc_sel_d;
         halted_q     <= halted_d;
      end
   end

   assign imem_req = imem_req_q;
   assign dmem_req = dmem_req_q;
   assign dmem_we  = dmem_we_q;
   assign ir_we    = imem_req_q & imem_ack;
   assign pc_we    = pc_we_q;
   assign rf_we    = rf_we_q;
   assign wb_sel   = wb_sel_q;
   assign pc_sel   = pc_sel_q;
   assign halted   = halted_q;
   assign err      = err_q;
   assign instret  = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed trap/timeout/reset cases on a MEM_TIMEOUT=4 instance,
// then randomized instruction streams on a default instance checked through a scoreboard.
module tb_multicycle_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   // instance A: default timeout, random stream
   logic a_rst, a_illegal, a_m2r, a_mw, a_rw, a_br, a_inv, a_jmp, a_nz, a_iack, a_dack;
   logic [1:0] a_npc;
   logic a_ireq, a_dreq, a_dwe, a_irwe, a_pcwe, a_rfwe, a_wbsel, a_halted;
   logic [1:0] a_pcsel, a_err;
   logic [31:0] a_instret;

   // instance B: MEM_TIMEOUT=4, directed
   logic b_rst, b_illegal, b_m2r, b_mw, b_rw, b_br, b_inv, b_jmp, b_nz, b_iack, b_dack;
   logic [1:0] b_npc;
   logic b_ireq, b_dreq, b_dwe, b_irwe, b_pcwe, b_rfwe, b_wbsel, b_halted;
   logic [1:0] b_pcsel, b_err;
   logic [31:0] b_instret;

   multicycle_ctrl #(.MEM_TIMEOUT(255)) dut_a (
      .clk(clk), .rst(a_rst), .illegal_instr(a_illegal), .mem_to_reg(a_m2r),
      .mem_write(a_mw), .reg_write(a_rw), .branch(a_br), .invert_branch(a_inv),
      .jump(a_jmp), .next_pc(a_npc), .alu_nz(a_nz), .imem_ack(a_iack), .dmem_ack(a_dack),
      .imem_req(a_ireq), .dmem_req(a_dreq), .dmem_we(a_dwe), .ir_we(a_irwe),
      .pc_we(a_pcwe), .rf_we(a_rfwe), .wb_sel(a_wbsel), .pc_sel(a_pcsel),
      .halted(a_halted), .err(a_err), .instret(a_instret)
   );

   multicycle_ctrl #(.MEM_TIMEOUT(4)) dut_b (
      .clk(clk), .rst(b_rst), .illegal_instr(b_illegal), .mem_to_reg(b_m2r),
      .mem_write(b_mw), .reg_write(b_rw), .branch(b_br), .invert_branch(b_inv),
      .jump(b_jmp), .next_pc(b_npc), .alu_nz(b_nz), .imem_ack(b_iack), .dmem_ack(b_dack),
      .imem_req(b_ireq), .dmem_req(b_dreq), .dmem_we(b_dwe), .ir_we(b_irwe),
      .pc_we(b_pcwe), .rf_we(b_rfwe), .wb_sel(b_wbsel), .pc_sel(b_pcsel),
      .halted(b_halted), .err(b_err), .instret(b_instret)
   );

   typedef struct {
      logic [1:0]  pc_sel;
      logic        rf_we;
      logic        wb_sel;
      logic        store;
      int unsigned wb_cyc;
      logic [31:0] instret;
   } exp_t;

   exp_t sb[$];
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_wait(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   // Scoreboard monitor for instance A
   exp_t m;
   always @(negedge clk) begin
      if (mon_en) begin
         if (a_pcwe) begin
            if (sb.size() == 0) begin
               fail_wait("a_unexpected_retire");
            end else begin
               m = sb.pop_front();
               chk("a_pc_sel", {30'd0, a_pcsel}, {30'd0, m.pc_sel});
               chk("a_rf_we", {31'd0, a_rfwe}, {31'd0, m.rf_we});
               chk("a_wb_sel", {31'd0, a_wbsel}, {31'd0, m.wb_sel});
               chk("a_instret", a_instret, m.instret);
               chk("a_wb_cycle", cyc, m.wb_cyc);
               chk("a_no_trap", {29'd0, a_halted, a_err}, 32'd0);
            end
         end
         if (a_dreq && sb.size() != 0) chk("a_dmem_we", {31'd0, a_dwe}, {31'd0, sb[0].store});
      end
   end

   task automatic rnd_acks_a();
      a_iack = 1'($urandom_range(0, 1));
      a_dack = 1'($urandom_range(0, 1));
   endtask

   task automatic run_a(input int n);
      int unsigned model_ret = 0;
      int unsigned wi, wd, s, k, kind;
      logic is_mem, taken;
      exp_t e;
      for (int i = 0; i < n; i++) begin
         kind = $urandom_range(0, 5);
         {a_m2r, a_mw, a_rw, a_br, a_jmp} = '0;
         a_npc = 2'($urandom_range(0, 3));
         a_nz  = 1'($urandom_range(0, 1));
         a_inv = 1'($urandom_range(0, 1));
         case (kind)
            0: a_rw = 1'b1;
            1: begin a_m2r = 1'b1; a_rw = 1'b1; end
            2: a_mw = 1'b1;
            3: begin a_br = 1'b1; a_npc = 2'b01; end
            4: begin a_jmp = 1'b1; a_rw = 1'b1; a_npc = 2'b01; end
            default: begin a_jmp = 1'b1; a_rw = 1'b1; a_npc = 2'b11; end
         endcase
         wi = $urandom_range(0, 3);
         wd = $urandom_range(0, 3);
         is_mem = a_m2r | a_mw;
         taken  = a_jmp | (a_br & (a_nz ^ a_inv));
         k = 0;
         while (!a_ireq && k < 16) begin rnd_acks_a(); @(negedge clk); k++; end
         if (!a_ireq) begin fail_wait("a_fetch_start"); return; end
         s = cyc;
         e.pc_sel  = taken ? a_npc : 2'b00;
         e.rf_we   = a_rw;
         e.wb_sel  = a_m2r;
         e.store   = a_mw;
         e.wb_cyc  = s + wi + 3 + (is_mem ? 1 + wd : 0);
         e.instret = model_ret;
         sb.push_back(e);
         model_ret++;
         repeat (wi) begin a_iack = 1'b0; a_dack = 1'($urandom_range(0, 1)); @(negedge clk); end
         a_iack = 1'b1;
         #1 chk("a_ir_we", {31'd0, a_irwe}, 32'd1);
         @(negedge clk);
         a_iack = 1'b0;
         if (is_mem) begin
            k = 0;
            while (!a_dreq && k < 8) begin rnd_acks_a(); @(negedge clk); k++; end
            if (!a_dreq) begin fail_wait("a_mem_start"); return; end
            repeat (wd) begin a_dack = 1'b0; a_iack = 1'($urandom_range(0, 1)); @(negedge clk); end
            a_dack = 1'b1;
            a_iack = 1'b0;
            @(negedge clk);
            a_dack = 1'b0;
         end
         k = 0;
         while (!a_pcwe && k < 8) begin rnd_acks_a(); @(negedge clk); k++; end
         if (!a_pcwe) begin fail_wait("a_retire"); return; end
      end
      @(negedge clk);
      chk("a_instret_final", a_instret, model_ret);
      chk("a_sb_drained", sb.size(), 0);
   endtask

   task automatic set_b(input logic rw, m2r, mw, br, inv, jmp, input logic [1:0] npc);
      b_rw = rw; b_m2r = m2r; b_mw = mw; b_br = br; b_inv = inv; b_jmp = jmp; b_npc = npc;
   endtask

   task automatic quiet_b(input int n, input logic [1:0] cause);
      int bad = 0;
      repeat (n) begin
         b_iack = 1'($urandom_range(0, 1));
         b_dack = 1'($urandom_range(0, 1));
         @(negedge clk);
         if ({b_ireq, b_dreq, b_dwe, b_irwe, b_pcwe, b_rfwe} != 6'd0 || !b_halted || b_err != cause)
            bad++;
      end
      b_iack = 1'b0;
      b_dack = 1'b0;
      chk("b_trap_quiet", bad, 0);
   endtask

   task automatic reset_b();
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      @(negedge clk);
   endtask

   // counts consecutive cycles a request stays high before the block traps
   task automatic count_req_b(input bit dmem, output int cnt);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         if (!(dmem ? b_dreq : b_ireq) || b_halted) break;
         cnt++;
         @(negedge clk);
      end
   endtask

   initial begin
      int cnt;
      {a_illegal, a_m2r, a_mw, a_rw, a_br, a_inv, a_jmp, a_nz, a_iack, a_dack} = '0;
      {b_illegal, b_m2r, b_mw, b_rw, b_br, b_inv, b_jmp, b_nz, b_iack, b_dack} = '0;
      a_npc = 2'b00;
      b_npc = 2'b00;
      a_rst = 1'b1;
      b_rst = 1'b1;
      repeat (2) @(negedge clk);

      chk("b_reset_outputs", {20'd0, b_ireq, b_dreq, b_dwe, b_irwe, b_pcwe, b_rfwe, b_wbsel,
          b_pcsel, b_halted, b_err}, 32'd0);
      chk("b_reset_instret", b_instret, 32'd0);
      chk("a_reset_outputs", {28'd0, a_ireq, a_pcwe, a_halted, a_err != 2'b00}, 32'd0);
      b_rst = 1'b0;
      @(negedge clk);
      chk("b_req_after_reset", {31'd0, b_ireq}, 32'd1);

      // imem never acks
      count_req_b(1'b0, cnt);
      chk("b_imem_wait_cycles", cnt, 4);
      chk("b_imem_timeout_err", {30'd0, b_err}, 32'd2);
      chk("b_imem_timeout_halt", {31'd0, b_halted}, 32'd1);
      quiet_b(20, 2'b10);
      reset_b();
      chk("b_err_cleared", {29'd0, b_halted, b_err}, 32'd0);
      chk("b_req_after_rst2", {31'd0, b_ireq}, 32'd1);

      // ack on exactly the limit cycle wins
      set_b(1, 0, 0, 0, 0, 0, 2'b01);
      repeat (3) begin b_iack = 1'b0; @(negedge clk); end
      b_iack = 1'b1;
      #1 chk("b_ir_we_limit", {31'd0, b_irwe}, 32'd1);
      @(negedge clk);
      b_iack = 1'b0;
      chk("b_no_trap_limit", {31'd0, b_halted}, 32'd0);
      repeat (2) @(negedge clk);
      chk("b_addi_wb", {28'd0, b_pcwe, b_rfwe, b_pcsel}, {28'd0, 4'b1100});
      chk("b_addi_instret_pre", b_instret, 32'd0);
      @(negedge clk);
      chk("b_addi_instret_post", b_instret, 32'd1);
      chk("b_addi_pc_we_pulse", {31'd0, b_pcwe}, 32'd0);

      // illegal instruction
      b_illegal = 1'b1;
      b_iack = 1'b1;
      @(negedge clk);
      b_iack = 1'b0;
      chk("b_decode_not_halted", {31'd0, b_halted}, 32'd0);
      @(negedge clk);
      chk("b_illegal_trap", {29'd0, b_halted, b_err}, {29'd0, 3'b101});
      quiet_b(20, 2'b01);
      b_illegal = 1'b0;
      reset_b();
      chk("b_illegal_cleared", {29'd0, b_halted, b_err}, 32'd0);
      chk("b_illegal_instret_rst", b_instret, 32'd0);

      // dmem never acks on a load
      set_b(1, 1, 0, 0, 0, 0, 2'b00);
      b_iack = 1'b1;
      @(negedge clk);
      b_iack = 1'b0;
      repeat (2) @(negedge clk);
      chk("b_mem_req", {30'd0, b_dreq, b_dwe}, 32'd2);
      count_req_b(1'b1, cnt);
      chk("b_dmem_wait_cycles", cnt, 4);
      chk("b_dmem_timeout_trap", {29'd0, b_halted, b_err}, {29'd0, 3'b111});
      reset_b();

      // reset landing on the WB edge must not retire
      set_b(1, 0, 0, 0, 0, 0, 2'b00);
      b_iack = 1'b1;
      @(negedge clk);
      b_iack = 1'b0;
      repeat (2) @(negedge clk);
      chk("b_wb_before_rst", {31'd0, b_pcwe}, 32'd1);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      chk("b_rst_wb_instret", b_instret, 32'd0);
      chk("b_rst_wb_quiet", {29'd0, b_ireq, b_pcwe, b_rfwe}, 32'd0);
      @(negedge clk);

      // reset mid-MEM
      set_b(0, 0, 1, 0, 0, 0, 2'b00);
      b_iack = 1'b1;
      @(negedge clk);
      b_iack = 1'b0;
      repeat (3) @(negedge clk);
      chk("b_store_mem", {30'd0, b_dreq, b_dwe}, 32'd3);
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      chk("b_rst_mem_quiet", {28'd0, b_ireq, b_dreq, b_pcwe, b_rfwe}, 32'd0);
      @(negedge clk);
      chk("b_rst_mem_refetch", {31'd0, b_ireq}, 32'd1);
      chk("b_rst_mem_instret", b_instret, 32'd0);

      // randomized stream on instance A
      a_rst = 1'b0;
      mon_en = 1'b1;
      run_a(200);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
